// File: rtl/wave_pwm_dac_nch_pkg.sv
// Shared definitions for the waveform PWM DAC and the CORDIC top:
// waveform-select encodings and per-channel control field widths.
package wave_pwm_dac_nch_pkg;

  typedef enum logic [1:0] {
    SEL_SIN = 2'd0,
    SEL_COS = 2'd1,
    SEL_TRI = 2'd2,
    SEL_SQR = 2'd3
  } sel_e;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned ATT_W = 3;

endpackage

// File: rtl/wave_pwm_dac_nch_if.sv
// Signal bundle of the multi-channel waveform PWM DAC.
//   sin_in/cos_in/tri_in/sqr_in : signed sources, shared by all channels
//   sel  : per-channel waveform select, SEL_W bits per channel
//   att  : per-channel arithmetic right-shift count, ATT_W bits per channel
//   en   : per-channel enable (0 = mute to midscale)
//   pwm  : per-channel registered PWM output
//   frame_stb : one-cycle pulse in the frame-boundary (capture) cycle
//   mon  : per-channel latched signed sample after attenuation
// master = source/control side, slave = DAC side.
interface wave_pwm_dac_nch_if #(
  parameter int WIDTH = 12,
  parameter int NCH   = 2
);
  import wave_pwm_dac_nch_pkg::*;

  logic [WIDTH-1:0]       sin_in;
  logic [WIDTH-1:0]       cos_in;
  logic [WIDTH-1:0]       tri_in;
  logic [WIDTH-1:0]       sqr_in;
  logic [SEL_W*NCH-1:0]   sel;
  logic [ATT_W*NCH-1:0]   att;
  logic [NCH-1:0]         en;
  logic [NCH-1:0]         pwm;
  logic                   frame_stb;
  logic [NCH*WIDTH-1:0]   mon;

  modport master (
    output sin_in, cos_in, tri_in, sqr_in, sel, att, en,
    input  pwm, frame_stb, mon
  );

  modport slave (
    input  sin_in, cos_in, tri_in, sqr_in, sel, att, en,
    output pwm, frame_stb, mon
  );
endinterface

// File: rtl/wave_pwm_dac_nch_pwm_chan.sv
// One PWM DAC channel: waveform select, attenuation shift, offset-binary
// conversion, duty register and compare/output flop.
//   clock, resetn : clock, async active-low reset
//   cap           : frame-boundary strobe; controls and source sampled here
//   cnt           : shared frame counter
//   sin_in..sqr_in: signed sources
//   sel, att, en  : this channel's controls
//   pwm           : registered PWM output
//   mon           : latched attenuated sample
module pwm_chan
  import wave_pwm_dac_nch_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cap,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] sin_in,
  input  logic [WIDTH-1:0] cos_in,
  input  logic [WIDTH-1:0] tri_in,
  input  logic [WIDTH-1:0] sqr_in,
  input  logic [SEL_W-1:0] sel,
  input  logic [ATT_W-1:0] att,
  input  logic             en,
  output logic             pwm,
  output logic [WIDTH-1:0] mon
);

  logic signed [WIDTH-1:0] src;
  logic signed [WIDTH-1:0] shifted;
  logic        [WIDTH-1:0] cap_val;
  logic        [WIDTH-1:0] duty;

  always_comb begin
    src = sin_in;
    case (sel_e'(sel))
      SEL_SIN: src = sin_in;
      SEL_COS: src = cos_in;
      SEL_TRI: src = tri_in;
      SEL_SQR: src = sqr_in;
    endcase
    shifted = src >>> att;
    cap_val = en ? shifted : '0;
  end

  // duty resets to 0 (not midscale) so the output stays low until the
  // first capture; hence it is held separately from mon.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mon  <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (cap) begin
        mon  <= cap_val;
        duty <= {~cap_val[WIDTH-1], cap_val[WIDTH-2:0]};
      end
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/wave_pwm_dac_nch.sv
// Multi-channel waveform PWM DAC. A free-running WIDTH-bit frame counter
// is shared by NCH channels; every channel captures its selected, attenuated
// source in the boundary cycle (cnt all ones) and uses it for the next frame.
//   clock  : single clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of wave_pwm_dac_nch_if (sources, controls, outputs)
module wave_pwm_dac_nch
  import wave_pwm_dac_nch_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NCH   = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  wave_pwm_dac_nch_if.slave      bus
);

  logic [WIDTH-1:0]     cnt;
  logic                 boundary;
  logic [NCH-1:0]       pwm_w;
  logic [NCH*WIDTH-1:0] mon_w;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt + WIDTH'(1);
  end

  // Decoded from cnt, so it is low whenever reset holds cnt at 0.
  assign boundary      = (cnt == '1);
  assign bus.frame_stb = boundary;
  assign bus.pwm       = pwm_w;
  assign bus.mon       = mon_w;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    pwm_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clock  (clock),
      .resetn (resetn),
      .cap    (boundary),
      .cnt    (cnt),
      .sin_in (bus.sin_in),
      .cos_in (bus.cos_in),
      .tri_in (bus.tri_in),
      .sqr_in (bus.sqr_in),
      .sel    (bus.sel[SEL_W*k +: SEL_W]),
      .att    (bus.att[ATT_W*k +: ATT_W]),
      .en     (bus.en[k]),
      .pwm    (pwm_w[k]),
      .mon    (mon_w[WIDTH*k +: WIDTH])
    );
  end

endmodule

// File: tb/tb_wave_pwm_dac_nch.sv
module tb_wave_pwm_dac_nch;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  wave_pwm_dac_nch_if #(.WIDTH(12), .NCH(2)) bus ();

  wave_pwm_dac_nch #(
    .WIDTH(12),
    .NCH  (2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Called at the negedge where reset was released (cycle 0). Ends at the
  // negedge of the first boundary cycle.
  task automatic first_frame_low(input string tag);
    int pwm_bad;
    int stb_bad;
    pwm_bad = 0;
    stb_bad = 0;
    if (bus.pwm !== 2'b00) pwm_bad++;
    if (bus.frame_stb !== 1'b0) stb_bad++;
    for (int i = 1; i <= 4095; i++) begin
      @(negedge clock);
      if (bus.pwm !== 2'b00) pwm_bad++;
      if (bus.frame_stb !== ((i == 4095) ? 1'b1 : 1'b0)) stb_bad++;
    end
    checks++;
    if (pwm_bad != 0) begin
      errors++;
      $display("FAIL %s_pwm_low: %0d cycles with pwm high, required 0", tag, pwm_bad);
    end
    checks++;
    if (stb_bad != 0) begin
      errors++;
      $display("FAIL %s_stb_4095: %0d misplaced frame_stb cycles, required 0", tag, stb_bad);
    end
  endtask

  // Called at the negedge of a boundary cycle. Counts high cycles of the
  // following frame (samples at cnt=1..4095 reflect compares at cnt=0..4094;
  // the cnt=4095 compare can never be true). Ends at the next boundary negedge.
  task automatic measure(input int chg_at, input string tag,
                         output int h0, output int h1,
                         output logic [11:0] m0, output logic [11:0] m1);
    int stb_bad;
    stb_bad = 0;
    h0 = 0;
    h1 = 0;
    @(negedge clock);
    m0 = bus.mon[11:0];
    m1 = bus.mon[23:12];
    if (bus.frame_stb !== 1'b0) stb_bad++;
    for (int i = 1; i <= 4095; i++) begin
      @(negedge clock);
      if (bus.pwm[0] === 1'b1) h0++;
      if (bus.pwm[1] === 1'b1) h1++;
      if (i == chg_at) begin
        bus.sel[1:0] = 2'd3;
        bus.sin_in   = 12'd5;
      end
      if (i < 4095 && bus.frame_stb !== 1'b0) stb_bad++;
    end
    checks++;
    if (bus.frame_stb !== 1'b1 || stb_bad != 0) begin
      errors++;
      $display("FAIL %s_stb: stb at boundary=%b stray=%0d, required 1 and 0",
               tag, bus.frame_stb, stb_bad);
    end
    checks++;
    if (bus.mon !== {m1, m0}) begin
      errors++;
      $display("FAIL %s_mon_stable: mon=%h at frame end, required %h", tag, bus.mon, {m1, m0});
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.pwm !== 2'b00) begin
      errors++;
      $display("FAIL rst_pwm: pwm=%b, required 00", bus.pwm);
    end
    checks++;
    if (bus.mon !== 24'h0) begin
      errors++;
      $display("FAIL rst_mon: mon=%h, required 000000", bus.mon);
    end
    checks++;
    if (bus.frame_stb !== 1'b0) begin
      errors++;
      $display("FAIL rst_stb: frame_stb=%b, required 0", bus.frame_stb);
    end
    // ch0: sin, no attenuation; ch1: tri, att 2
    bus.en     = 2'b11;
    bus.sel    = {2'd2, 2'd0};
    bus.att    = {3'd2, 3'd0};
    bus.sin_in = 12'h800;
    bus.tri_in = 12'd1024;
    resetn = 1'b1;
    first_frame_low("rst");
  endtask

  task automatic test_extremes_atten;
    int h0, h1;
    logic [11:0] m0, m1;

    measure(0, "ext_a", h0, h1, m0, m1);
    checks++;
    if (h0 !== 0)    begin errors++; $display("FAIL ext_neg_high: %0d, required 0", h0); end
    checks++;
    if (m0 !== 12'h800) begin errors++; $display("FAIL ext_neg_mon0: %h, required 800", m0); end
    checks++;
    if (h1 !== 2304) begin errors++; $display("FAIL att_pos_high: %0d, required 2304", h1); end
    checks++;
    if (m1 !== 12'h100) begin errors++; $display("FAIL att_pos_mon1: %h, required 100", m1); end

    bus.sin_in = 12'h000;
    bus.tri_in = 12'hC00;
    measure(0, "ext_b", h0, h1, m0, m1);
    checks++;
    if (h0 !== 2048) begin errors++; $display("FAIL ext_zero_high: %0d, required 2048", h0); end
    checks++;
    if (m0 !== 12'h000) begin errors++; $display("FAIL ext_zero_mon0: %h, required 000", m0); end
    checks++;
    if (h1 !== 1792) begin errors++; $display("FAIL att_neg_high: %0d, required 1792", h1); end
    checks++;
    if (m1 !== 12'hF00) begin errors++; $display("FAIL att_neg_mon1: %h, required f00", m1); end

    bus.sin_in = 12'h7FF;
    measure(0, "ext_c", h0, h1, m0, m1);
    checks++;
    if (h0 !== 4095) begin errors++; $display("FAIL ext_max_high: %0d, required 4095", h0); end
    checks++;
    if (m0 !== 12'h7FF) begin errors++; $display("FAIL ext_max_mon0: %h, required 7ff", m0); end
  endtask

  task automatic test_mute;
    int h0, h1;
    logic [11:0] m0, m1;
    bus.en     = 2'b10;
    bus.sin_in = 12'h7FF;
    bus.tri_in = 12'd1024;
    measure(0, "mute", h0, h1, m0, m1);
    checks++;
    if (m0 !== 12'h000) begin errors++; $display("FAIL mute_mon0: %h, required 000", m0); end
    checks++;
    if (h0 !== 2048) begin errors++; $display("FAIL mute_high0: %0d, required 2048", h0); end
    checks++;
    if (m1 !== 12'h100) begin errors++; $display("FAIL mute_mon1: %h, required 100", m1); end
    checks++;
    if (h1 !== 2304) begin errors++; $display("FAIL mute_high1: %0d, required 2304", h1); end
  endtask

  task automatic test_midframe;
    int h0, h1;
    logic [11:0] m0, m1;
    bus.en     = 2'b11;
    bus.sel    = {2'd2, 2'd0};
    bus.sin_in = 12'd1000;
    bus.sqr_in = 12'h7FF;
    // sel0 -> sqr and sin_in -> 5 at cnt=1000 inside measure
    measure(1000, "mid_a", h0, h1, m0, m1);
    checks++;
    if (h0 !== 3048) begin errors++; $display("FAIL mid_hold_high: %0d, required 3048", h0); end
    checks++;
    if (m0 !== 12'h3E8) begin errors++; $display("FAIL mid_hold_mon0: %h, required 3e8", m0); end
    measure(0, "mid_b", h0, h1, m0, m1);
    checks++;
    if (h0 !== 4095) begin errors++; $display("FAIL mid_new_high: %0d, required 4095", h0); end
    checks++;
    if (m0 !== 12'h7FF) begin errors++; $display("FAIL mid_new_mon0: %h, required 7ff", m0); end
  endtask

  task automatic test_reset_midframe;
    repeat (1500) @(negedge clock);
    checks++;
    if (bus.pwm[0] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre_pwm0: pwm0=%b, required 1", bus.pwm[0]);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.pwm !== 2'b00) begin
      errors++;
      $display("FAIL rmid_pwm: pwm=%b, required 00", bus.pwm);
    end
    checks++;
    if (bus.mon !== 24'h0) begin
      errors++;
      $display("FAIL rmid_mon: mon=%h, required 000000", bus.mon);
    end
    checks++;
    if (bus.frame_stb !== 1'b0) begin
      errors++;
      $display("FAIL rmid_stb: frame_stb=%b, required 0", bus.frame_stb);
    end
    @(negedge clock);
    resetn = 1'b1;
    first_frame_low("rmid");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clock  = 1'b0;
    resetn = 1'b0;
    bus.sin_in = '0;
    bus.cos_in = '0;
    bus.tri_in = '0;
    bus.sqr_in = '0;
    bus.sel    = '0;
    bus.att    = '0;
    bus.en     = '0;

    test_reset();
    test_extremes_atten();
    test_mute();
    test_midframe();
    test_reset_midframe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_pwm_dac_nch.md
WAVE_PWM_DAC_NCH -- requirements
Module: wave_pwm_dac_nch

Interface
REQ-001 SHALL have parameter WIDTH, default 12: sample width and PWM counter width; legal range 8..16.
REQ-002 SHALL have parameter NCH, default 2: number of independent PWM output channels; legal range 1..8.
REQ-003 SHALL have port clock, input, 1: single clock for all logic.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port sin_in, input, WIDTH: signed sine source, shared by all channels.
REQ-006 SHALL have port cos_in, input, WIDTH: signed cosine source.
REQ-007 SHALL have port tri_in, input, WIDTH: signed triangle source.
REQ-008 SHALL have port sqr_in, input, WIDTH: signed square source.
REQ-009 SHALL have port sel, input, 2*NCH: per-channel waveform select; field k = sel[2k+1:2k]; 0=sin, 1=cos, 2=tri, 3=sqr.
REQ-010 SHALL have port att, input, 3*NCH: per-channel attenuation, arithmetic right-shift count 0..7.
REQ-011 SHALL have port en, input, NCH: per-channel enable; 0 = mute to midscale.
REQ-012 SHALL have port pwm, output, NCH: registered PWM outputs.
REQ-013 SHALL have port frame_stb, output, 1: one-cycle pulse in the frame-boundary (capture) cycle.
REQ-014 SHALL have port mon, output, NCH*WIDTH: per-channel latched signed sample, after attenuation, for display.

Function
REQ-015 SHALL run one free-running WIDTH-bit frame counter cnt from 0 to 2^WIDTH-1, then wrap to 0; a frame is 2^WIDTH cycles.
REQ-016 SHALL treat the cycle with cnt == 2^WIDTH-1 as the boundary cycle and assert frame_stb only in that cycle.
REQ-017 SHALL, in the boundary cycle per channel: sample sel, att and en; select the source; arithmetic-shift it right by att with sign extension; latch the result into mon.
REQ-018 SHALL convert the latched value to duty by inverting its MSB (offset binary): -2^(WIDTH-1) -> 0, 0 -> 2^(WIDTH-1), 2^(WIDTH-1)-1 -> 2^WIDTH-1.
REQ-019 SHALL, when the sampled en bit is 0, latch mon = 0 and duty = 2^(WIDTH-1) regardless of sel and att.
REQ-020 SHALL apply new duty from the cycle after the boundary (cnt == 0); capture-to-use latency is 1 cycle.
REQ-021 SHALL drive pwm[k] high in a cycle iff the cnt value of the previous cycle < duty[k]; output is registered, one cycle behind the compare.
REQ-022 SHALL give duty 0 a constant-low output and duty 2^WIDTH-1 a high output for 2^WIDTH-1 cycles per frame; no 100 % state.
REQ-023 SHALL ignore changes on sel, att, en and the source inputs away from the boundary cycle; duty, mon and pwm are glitch-free within a frame.
REQ-024 SHALL update all channels in the same boundary cycle; no per-channel skew.

Reset
REQ-025 SHALL, while resetn is low, asynchronously force cnt = 0, all duty = 0, mon = 0, pwm = 0 and frame_stb = 0.
REQ-026 SHALL start the first frame after reset release with cnt = 0 and duty = 0, so pwm stays low until the first boundary capture.
REQ-027 SHALL abort a frame when reset is asserted mid-frame; no partial state persists.

Structure
REQ-028 SHALL place waveform-select encodings (SEL_SIN=0, SEL_COS=1, SEL_TRI=2, SEL_SQR=3) and the attenuation field width (3) in a shared package/include used with the CORDIC top.
REQ-029 SHALL implement each channel as sub-module pwm_chan, generated NCH times: select, shift, offset conversion, duty register, compare and output flop.
REQ-030 SHALL keep the frame counter and frame_stb in the parent module, with one cnt shared by all channels.

Verification (WIDTH=12, NCH=2)
REQ-031 SHALL cover reset: resetn low at an arbitrary cycle -> pwm=0, mon=0 and frame_stb=0 immediately; after release, the first 4096 cycles have pwm=0, and frame_stb pulses at cycle 4095.
REQ-032 SHALL cover extremes: ch0 sel=0 with sin_in = -2048, 0 and 2047 over successive frames -> high counts per frame of 0, 2048 and 4095.
REQ-033 SHALL cover attenuation: ch1 sel=2, tri_in=1024, att=2 -> mon1=256 and 2304 high cycles/frame; tri_in=-1024, att=2 -> mon1=-256 and 1792 high cycles.
REQ-034 SHALL cover mid-frame change: sel is changed from 0 to 3 at cnt=1000 -> duty stays unchanged to the end of the frame; the new duty applies from the next cnt=0.
REQ-035 SHALL cover mute: en[0]=0 with sin_in=2047 -> mon0=0 and 2048 high cycles/frame; ch1 is unaffected.
